// File: rtl/key_debouncer_if.sv
// Key debouncer signal bundle: raw key in, debounced level and press/release pulses out.
// master = key source / consumer side, slave = the debouncer itself.
interface key_debouncer_if;
  logic iKey;
  logic oKey;
  logic oPress;
  logic oRelease;

  modport master (output iKey, input oKey, oPress, oRelease);
  modport slave  (input iKey, output oKey, oPress, oRelease);
endinterface

// File: rtl/key_debouncer.sv
// Push-button debouncer: 2-flop sync + 4-state stability FSM; oKey moves STABLE_CYCLES+2 edges after input change.
// No backpressure (pulses are fire-and-forget); KEY_DEBOUNCER_REPEAT_EN adds auto-repeat oPress every REPEAT_CYCLES while held.
module key_debouncer #(
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned REPEAT_CYCLES = 25000000
) (
  input  logic     iClk,
  input  logic     iRst,
  key_debouncer_if.slave keyIf
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam bit PARAMS_OK = (STABLE_CYCLES >= 32'd2) && (STABLE_CYCLES <= 32'd16777216) &&
                             (REPEAT_CYCLES >= 32'd2) && (REPEAT_CYCLES <= 32'd67108864);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic             syncMeta;
  logic             sKey;
  logic             keyQ;
  logic             pressQ;
  logic             releaseQ;
  logic             pressNext;
  logic             releaseNext;
  logic             repeatFire;

  // Raw key is asynchronous; nothing downstream may see it before two flops.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      syncMeta <= 1'b1;
      sKey     <= 1'b1;
    end else begin
      syncMeta <= keyIf.iKey;
      sKey     <= syncMeta;
    end
  end

`ifdef KEY_DEBOUNCER_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] repCnt;

  assign repeatFire = (state == PRESSED) && !sKey && (repCnt == REP_LAST);

  // Counts only while the key stays accepted-pressed; any exit toward release restarts it.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      repCnt <= '0;
    end else if (state == PRESSED && stateNext == PRESSED) begin
      repCnt <= repeatFire ? '0 : repCnt + REP_W'(1);
    end else begin
      repCnt <= '0;
    end
  end
`else
  assign repeatFire = 1'b0;
`endif

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    pressNext   = 1'b0;
    releaseNext = 1'b0;
    case (state)
      RELEASED: begin
        if (!sKey) begin
          stateNext = PRESS_WAIT;
          cntNext   = '0;
        end
      end
      PRESS_WAIT: begin
        if (sKey) begin
          stateNext = RELEASED;
        end else if (cnt == CNT_LAST) begin
          stateNext = PRESSED;
          pressNext = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (sKey) begin
          stateNext = RELEASE_WAIT;
          cntNext   = '0;
        end else if (repeatFire) begin
          pressNext = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (!sKey) begin
          stateNext = PRESSED;
        end else if (cnt == CNT_LAST) begin
          stateNext   = RELEASED;
          releaseNext = 1'b1;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = RELEASED;
        cntNext   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so oKey and the pulses land in the same cycle.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= RELEASED;
      cnt      <= '0;
      keyQ     <= 1'b1;
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      keyQ     <= !((stateNext == PRESSED) || (stateNext == RELEASE_WAIT));
      pressQ   <= pressNext;
      releaseQ <= releaseNext;
    end
  end

  assign keyIf.oKey     = keyQ;
  assign keyIf.oPress   = pressQ;
  assign keyIf.oRelease = releaseQ;

  assert property (@(posedge iClk) PARAMS_OK);
  assert property (@(posedge iClk) disable iff (iRst) !(pressQ && releaseQ));
  assert property (@(posedge iClk) disable iff (iRst) pressQ |=> !pressQ);
  assert property (@(posedge iClk) disable iff (iRst) releaseQ |=> !releaseQ);
  assert property (@(posedge iClk) disable iff (iRst) pressQ |-> !keyQ);
  assert property (@(posedge iClk) disable iff (iRst) releaseQ |-> keyQ);

endmodule

// File: tb/tb_key_debouncer.sv
// Scoreboard bench for key_debouncer with STABLE_CYCLES=4, REPEAT_CYCLES=10.
// Expected pulses (edge number + kind) are queued when the key is driven and matched by a negedge monitor.
module tb_key_debouncer;

  localparam int STABLE = 4;
  localparam int REPEAT = 10;
  localparam int LAT    = STABLE + 2;

  typedef struct {
    int edgeNo;
    bit isPress;
  } ev_t;

  logic iClk = 1'b0;
  logic iRst = 1'b1;
  int   edgeCnt = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  expQ[$];

  key_debouncer_if kif ();

  key_debouncer #(
    .STABLE_CYCLES(STABLE),
    .REPEAT_CYCLES(REPEAT)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .keyIf(kif)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) edgeCnt <= edgeCnt + 1;

  // Every pulse the DUT produces must match the head of the expectation queue.
  always @(negedge iClk) begin
    if (!iRst && (kif.oPress || kif.oRelease)) begin
      ev_t e;
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse edge=%0d press=%0b release=%0b expected none", edgeCnt, kif.oPress, kif.oRelease);
      end else begin
        e = expQ.pop_front();
        if (e.edgeNo !== edgeCnt || {kif.oPress, kif.oRelease} !== {e.isPress, !e.isPress}) begin
          bad++;
          $display("FAIL pulse_match got edge=%0d press=%0b release=%0b want edge=%0d press=%0b release=%0b",
                   edgeCnt, kif.oPress, kif.oRelease, e.edgeNo, e.isPress, !e.isPress);
        end
      end
    end
  end

  task automatic waitUntil(input int target);
    while (edgeCnt < target) @(negedge iClk);
  endtask

  task automatic test_reset;
    kif.iKey = 1'b1;
    iRst = 1'b1;
    @(negedge iClk);
    @(negedge iClk);
    total++;
    if (kif.oKey !== 1'b1) begin bad++; $display("FAIL reset_oKey got=%0b want=1", kif.oKey); end
    total++;
    if (kif.oPress !== 1'b0) begin bad++; $display("FAIL reset_oPress got=%0b want=0", kif.oPress); end
    total++;
    if (kif.oRelease !== 1'b0) begin bad++; $display("FAIL reset_oRelease got=%0b want=0", kif.oRelease); end
    iRst = 1'b0;
    repeat (4) @(negedge iClk);
    total++;
    if (kif.oKey !== 1'b1) begin bad++; $display("FAIL idle_oKey got=%0b want=1", kif.oKey); end
  endtask

  task automatic test_press_latency;
    int e;
    int f;
    kif.iKey = 1'b0;
    e = edgeCnt + 1;
    expQ.push_back('{e + LAT, 1'b1});
    waitUntil(e + LAT - 1);
    total++;
    if (kif.oKey !== 1'b1) begin bad++; $display("FAIL lat_oKey_early got=%0b want=1", kif.oKey); end
    @(negedge iClk);
    total++;
    if (kif.oKey !== 1'b0 || kif.oPress !== 1'b1) begin
      bad++; $display("FAIL lat_accept got oKey=%0b oPress=%0b want oKey=0 oPress=1", kif.oKey, kif.oPress);
    end
    @(negedge iClk);
    total++;
    if (kif.oKey !== 1'b0 || kif.oPress !== 1'b0) begin
      bad++; $display("FAIL lat_after got oKey=%0b oPress=%0b want oKey=0 oPress=0", kif.oKey, kif.oPress);
    end
    @(negedge iClk);
    kif.iKey = 1'b1;
    f = edgeCnt + 1;
    expQ.push_back('{f + LAT, 1'b0});
    waitUntil(f + LAT - 1);
    total++;
    if (kif.oKey !== 1'b0) begin bad++; $display("FAIL rel_oKey_early got=%0b want=0", kif.oKey); end
    @(negedge iClk);
    total++;
    if (kif.oKey !== 1'b1 || kif.oRelease !== 1'b1) begin
      bad++; $display("FAIL rel_accept got oKey=%0b oRelease=%0b want oKey=1 oRelease=1", kif.oKey, kif.oRelease);
    end
    @(negedge iClk);
    total++;
    if (kif.oRelease !== 1'b0) begin bad++; $display("FAIL rel_after got=%0b want=0", kif.oRelease); end
    total++;
    if (expQ.size() !== 0) begin bad++; $display("FAIL lat_drain pending=%0d want=0", expQ.size()); end
  endtask

  task automatic test_bounce_reject;
    int e;
    int f;
    kif.iKey = 1'b0;
    repeat (3) @(negedge iClk);
    kif.iKey = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge iClk);
      total++;
      if (kif.oKey !== 1'b1) begin bad++; $display("FAIL bounce_oKey cycle=%0d got=%0b want=1", i, kif.oKey); end
    end
    // A fresh press must need the full stability window again.
    kif.iKey = 1'b0;
    e = edgeCnt + 1;
    expQ.push_back('{e + LAT, 1'b1});
    waitUntil(e + LAT + 1);
    kif.iKey = 1'b1;
    f = edgeCnt + 1;
    expQ.push_back('{f + LAT, 1'b0});
    waitUntil(f + LAT + 2);
    total++;
    if (expQ.size() !== 0) begin bad++; $display("FAIL bounce_drain pending=%0d want=0", expQ.size()); end
  endtask

  task automatic test_release_bounce;
    int e;
    int f;
    bit lvl[6];
    int len[6];
    lvl = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    len = '{1, 2, 1, 1, 2, 1};
    kif.iKey = 1'b0;
    e = edgeCnt + 1;
    expQ.push_back('{e + LAT, 1'b1});
    waitUntil(e + LAT);
    for (int i = 0; i < 6; i++) begin
      kif.iKey = lvl[i];
      for (int j = 0; j < len[i]; j++) begin
        @(negedge iClk);
        total++;
        if (kif.oKey !== 1'b0) begin bad++; $display("FAIL burst_oKey step=%0d got=%0b want=0", i, kif.oKey); end
      end
    end
    kif.iKey = 1'b1;
    f = edgeCnt + 1;
    expQ.push_back('{f + LAT, 1'b0});
    waitUntil(f + LAT + 1);
    total++;
    if (kif.oKey !== 1'b1) begin bad++; $display("FAIL burst_final_oKey got=%0b want=1", kif.oKey); end
    total++;
    if (expQ.size() !== 0) begin bad++; $display("FAIL burst_drain pending=%0d want=0", expQ.size()); end
  endtask

  task automatic test_reset_mid_press;
    int e;
    int r;
    int f;
    kif.iKey = 1'b0;
    e = edgeCnt + 1;
    expQ.push_back('{e + LAT, 1'b1});
    waitUntil(e + LAT + 2);
    iRst = 1'b1;
    #1;
    total++;
    if (kif.oKey !== 1'b1 || kif.oPress !== 1'b0 || kif.oRelease !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got oKey=%0b oPress=%0b oRelease=%0b want 1/0/0", kif.oKey, kif.oPress, kif.oRelease);
    end
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
    r = edgeCnt + 1;
    expQ.push_back('{r + LAT, 1'b1});
    waitUntil(r + LAT + 1);
    total++;
    if (kif.oKey !== 1'b0) begin bad++; $display("FAIL midrst_repress_oKey got=%0b want=0", kif.oKey); end
    kif.iKey = 1'b1;
    f = edgeCnt + 1;
    expQ.push_back('{f + LAT, 1'b0});
    waitUntil(f + LAT + 2);
    total++;
    if (expQ.size() !== 0) begin bad++; $display("FAIL midrst_drain pending=%0d want=0", expQ.size()); end
  endtask

  task automatic test_back_to_back;
    int e;
    int h;
    for (int n = 0; n < 4; n++) begin
      kif.iKey = 1'b0;
      e = edgeCnt + 1;
      expQ.push_back('{e + LAT, 1'b1});
      h = int'($urandom_range(9, 6));
      waitUntil(e + h - 1);
      kif.iKey = 1'b1;
      e = edgeCnt + 1;
      expQ.push_back('{e + LAT, 1'b0});
      h = int'($urandom_range(9, 6));
      waitUntil(e + h - 1);
    end
    waitUntil(edgeCnt + LAT + 2);
    total++;
    if (expQ.size() !== 0) begin bad++; $display("FAIL b2b_drain pending=%0d want=0", expQ.size()); end
  endtask

  task automatic test_repeat;
    int e;
    int a;
    int f;
    kif.iKey = 1'b0;
    e = edgeCnt + 1;
    a = e + LAT;
    expQ.push_back('{a, 1'b1});
`ifdef KEY_DEBOUNCER_REPEAT_EN
    for (int k = 1; k <= 4; k++) expQ.push_back('{a + k * REPEAT, 1'b1});
`endif
    waitUntil(a + 4 * REPEAT - 1);
    kif.iKey = 1'b1;
    f = edgeCnt + 1;
    expQ.push_back('{f + LAT, 1'b0});
    waitUntil(f + LAT + 2);
    total++;
    if (kif.oKey !== 1'b1) begin bad++; $display("FAIL repeat_final_oKey got=%0b want=1", kif.oKey); end
    total++;
    if (expQ.size() !== 0) begin bad++; $display("FAIL repeat_drain pending=%0d want=0", expQ.size()); end
  endtask

  initial begin
    kif.iKey = 1'b1;
    test_reset();
    test_press_latency();
    test_bounce_reject();
    test_release_bounce();
    test_reset_mid_press();
    test_back_to_back();
    test_repeat();
    repeat (3) @(negedge iClk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d limit reached", edgeCnt);
    $fatal(1, "watchdog");
  end

endmodule
